stcf_event_gate: RTL

//  Downstream stage of the STCF MLP denoiser. Buffers each raw DVS event in order while the MLP scores it,

---
 rtl/stcf_event_gate.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/stcf_event_gate.sv
// stcf_event_gate: buffers raw DVS events, pairs each MLP score with the oldest event, forwards on score >= threshold.
// Optional feature macro STCF_GATE_SCORE_OUT_EN adds m_tuser carrying the score of the forwarded event.
module stcf_event_gate #(
    parameter int EV_W  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            ev_tvalid,
    output logic            ev_tready,
    input  logic [EV_W-1:0] ev_tdata,
    input  logic            sc_tvalid,
    output logic            sc_tready,
    input  logic [15:0]     sc_tdata,
    input  logic [15:0]     thr_in,
    input  logic            thr_en,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [EV_W-1:0] m_tdata,
`ifdef STCF_GATE_SCORE_OUT_EN
    output logic [15:0]     m_tuser,
`endif
    output logic [31:0]     pass_cnt,
    output logic [31:0]     drop_cnt,
    output logic            ovf_flag
);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [EV_W-1:0]    mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               full;
    logic               empty;
    logic               active;
    logic               push;
    logic               pop;
    logic               pass;
    logic               take;
    logic               starve;
    logic               starve_q;
    logic signed [15:0] threshold;
    out_state_t         state;
    out_state_t         state_next;

    // Extra pointer MSB distinguishes a wrapped-full FIFO from an empty one.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_tready = active && !full;
    assign push      = ev_tvalid && ev_tready;

    assign m_tvalid  = (state == OUT_FULL);
    assign sc_tready = !empty && (!m_tvalid || m_tready);
    assign pop       = sc_tvalid && sc_tready;
    assign pass      = $signed(sc_tdata) >= threshold;
    assign take      = pop && pass;
    assign starve    = sc_tvalid && empty && !ev_tvalid;

    // ev_tready stays low until the first clock edge after reset release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ev_tdata;
        end
    end

    // A threshold written this cycle only affects scores accepted from the next cycle on.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            threshold <= '0;
        end else if (thr_en) begin
            threshold <= $signed(thr_in);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: begin
                if (take) begin
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (m_tready && !take) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tdata <= '0;
        end else if (take) begin
            m_tdata <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef STCF_GATE_SCORE_OUT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tuser <= '0;
        end else if (take) begin
            m_tuser <= sc_tdata;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else if (pop) begin
            if (pass && pass_cnt != CNT_MAX) begin
                pass_cnt <= pass_cnt + 32'd1;
            end
            if (!pass && drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    // A score waiting on an empty FIFO for two straight cycles with no event arriving means lost pairing.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            starve_q <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            starve_q <= starve;
            if (starve && starve_q) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule
